// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 32 shift-add or restoring-divide steps
// through the shared ALU, then a sign-fix cycle that registers the result.
module muldiv_sequencer #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ITERS   = 32,
   parameter logic [9:0]  ALU_ADD = 10'h000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [9:0]      alu_func,
   input  logic [XLEN-1:0] alu_out
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINISH} state_t;

   state_t            state, state_next;
   logic [4:0]        cnt;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   acc;    // product high word / partial remainder
   logic [XLEN-1:0]   sh;     // multiplier shift register / quotient
   logic [XLEN-1:0]   opnd;   // |multiplicand| or neg_d
   logic              neg_res;

   logic              s1, s2, dz;
   logic [XLEN-1:0]   mag1, mag2;
   logic [XLEN-1:0]   step_a, step_b;
   logic              carry, ge;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   dval, dval_s, fin_val;

   // Start decode: sign flags, operand magnitudes, divide-by-zero
   always_comb begin
      s1   = rs1[XLEN-1] & (op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
      s2   = rs2[XLEN-1] & (op inside {3'b000, 3'b001, 3'b100, 3'b110});
      mag1 = s1 ? -rs1 : rs1;
      mag2 = s2 ? -rs2 : rs2;
      dz   = op[2] & (rs2 == '0);
   end

   // One iteration step: divide uses r' = {r[31:0], q[31]}
   always_comb begin
      if (op_q[2]) begin
         step_a = {acc[XLEN-2:0], sh[XLEN-1]};
         step_b = opnd;
      end else begin
         step_a = acc;
         step_b = sh[0] ? opnd : '0;
      end
      carry = (alu_out < step_a);
      ge    = acc[XLEN-1] | carry;
   end

   // Sign fix and result select
   always_comb begin
      prod    = {acc, sh};
      prod_s  = neg_res ? -prod : prod;
      dval    = op_q[1] ? acc : sh;
      dval_s  = neg_res ? -dval : dval;
      fin_val = dval_s;
      if (!op_q[2])
         fin_val = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_next = state;
      alu_a      = '0;
      alu_b      = '0;
      alu_func   = ALU_ADD;
      case (state)
         S_IDLE:
            if (start) state_next = dz ? S_FINISH : S_ITER;
         S_ITER: begin
            alu_a = step_a;
            alu_b = step_b;
            if (cnt == 5'(ITERS - 1)) state_next = S_FINISH;
         end
         S_FINISH:
            state_next = S_IDLE;
         default:
            state_next = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         acc     <= '0;
         sh      <= '0;
         opnd    <= '0;
         neg_res <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         state <= state_next;
         done  <= (state == S_FINISH);
         case (state)
            S_IDLE:
               if (start) begin
                  op_q <= op;
                  cnt  <= '0;
                  // Divide-by-zero preloads the operands so FINISH's normal select yields -1 / rs1
                  if (dz) begin
                     acc     <= rs1;
                     sh      <= '1;
                     opnd    <= '0;
                     neg_res <= 1'b0;
                  end else if (op[2]) begin
                     acc     <= '0;
                     sh      <= mag1;
                     opnd    <= -mag2;
                     neg_res <= (op[1:0] == 2'b10) ? s1 : (s1 ^ s2);
                  end else begin
                     acc     <= '0;
                     sh      <= mag2;
                     opnd    <= mag1;
                     neg_res <= s1 ^ s2;
                  end
               end
            S_ITER: begin
               cnt <= cnt + 5'd1;
               if (op_q[2]) begin
                  acc <= ge ? alu_out : step_a;
                  sh  <= {sh[XLEN-2:0], ge};
               end else begin
                  acc <= {carry, alu_out[XLEN-1:1]};
                  sh  <= {alu_out[0], sh[XLEN-1:1]};
               end
            end
            S_FINISH:
               result <= fin_val;
            default: ;
         endcase
      end
   end

endmodule
